// File: rtl/arm_mem_pkg.sv
// Shared types for the data-memory SRAM responder:
// FSM state encoding and external SRAM bus widths.
package arm_mem_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } mem_state_e;

    function automatic logic [SRAM_ADDR_W-1:0] half_addr(
        input logic [SRAM_ADDR_W-2:0] word,
        input logic                   hi
    );
        return {word, hi};
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1 while enabled,
// flags terminal count and wraps to zero for the next phase.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Data-memory responder: services 32-bit MEM-stage loads/stores as two
// half-word accesses on a 16-bit async SRAM, stalling via ready.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BASE   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_r_en,
    input  logic                   MEM_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic [SRAM_DATA_W-1:0] SRAM_DQ_out,
    input  logic [SRAM_DATA_W-1:0] SRAM_DQ_in,
    output logic                   SRAM_DQ_oe,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    mem_state_e state_q, state_d;

    logic                   wr_q;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [31:0]            wdata_q;
    logic [SRAM_DATA_W-1:0] lo_q;
    logic [31:0]            rdata_q;

    logic                   req;
    logic                   busy;
    logic                   tc;
    logic [SRAM_ADDR_W-2:0] word_in;

    assign req     = MEM_r_en | MEM_w_en;
    assign busy    = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign word_in = (SRAM_ADDR_W-1)'((address - 32'(ADDR_BASE)) >> 2);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr_i(state_q == ST_IDLE),
        .en_i (busy),
        .tc_o (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req) state_d = ST_LOW;
            ST_LOW:  if (tc)  state_d = ST_HIGH;
            ST_HIGH: if (tc)  state_d = ST_DONE;
            ST_DONE:          state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Simultaneous read+write requests resolve to a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == ST_IDLE && req) begin
                wr_q    <= MEM_w_en;
                word_q  <= word_in;
                wdata_q <= write_data;
            end
            if (state_q == ST_LOW && tc && !wr_q) begin
                lo_q <= SRAM_DQ_in;
            end
            if (state_q == ST_HIGH && tc && !wr_q) begin
                rdata_q <= {SRAM_DQ_in, lo_q};
            end
        end
    end

    always_comb begin
        ready       = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_DQ_out = '0;
        SRAM_DQ_oe  = 1'b0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        unique case (state_q)
            ST_IDLE: ready = ~req;
            ST_LOW, ST_HIGH: begin
                SRAM_ADDR = half_addr(word_q, state_q == ST_HIGH);
                if (wr_q) begin
                    SRAM_DQ_oe  = 1'b1;
                    SRAM_WE_N   = 1'b0;
                    SRAM_DQ_out = (state_q == ST_HIGH) ?
                                  wdata_q[31:16] : wdata_q[15:0];
                end else begin
                    SRAM_OE_N = 1'b0;
                end
            end
            ST_DONE: ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a cycle-level transaction
// model, an SRAM pad model and per-cycle output comparison.
module tb_sram_controller;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic        MEM_r_en;
    logic        MEM_w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_DQ_oe;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 0;

    sram_controller #(
        .WAIT_CYCLES(W),
        .ADDR_BASE  (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_r_en   (MEM_r_en),
        .MEM_w_en   (MEM_w_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_out(SRAM_DQ_out),
        .SRAM_DQ_in (SRAM_DQ_in),
        .SRAM_DQ_oe (SRAM_DQ_oe),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // SRAM pad model
    logic [15:0] sram [0:15];
    initial for (int i = 0; i < 16; i++) sram[i] = 16'h0;
    assign SRAM_DQ_in = !SRAM_OE_N ? sram[SRAM_ADDR[3:0]] : 16'h0;
    always @(posedge clk) begin
        if (!SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR[3:0]] <= SRAM_DQ_out;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: mt = cycle index within the access, -1 when idle
    int          mt = -1;
    logic        mwr = 0;
    logic [16:0] mword = 0;
    logic [31:0] mdata = 0;
    logic [31:0] m_rd = 0;
    logic [31:0] mw [0:7];
    initial for (int i = 0; i < 8; i++) mw[i] = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            mt   <= -1;
            m_rd <= 32'h0;
        end else if (mt < 0) begin
            if (MEM_r_en || MEM_w_en) begin
                mt    <= 1;
                mwr   <= MEM_w_en;
                mword <= 17'((address - 32'd1024) >> 2);
                mdata <= write_data;
            end
        end else if (mt == 2*W + 1) begin
            mt <= -1;
        end else begin
            mt <= mt + 1;
            if (mt == 2*W) begin
                if (mwr) mw[mword[2:0]] <= mdata;
                else     m_rd <= mw[mword[2:0]];
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit ph_lo, ph_hi, act;
        if (chk_on) begin
            ph_lo = (mt >= 1) && (mt <= W);
            ph_hi = (mt > W) && (mt <= 2*W);
            act   = ph_lo || ph_hi;
            check("ready", 32'(ready),
                  32'((mt < 0) ? !(MEM_r_en || MEM_w_en) : (mt == 2*W + 1)));
            check("we_n", 32'(SRAM_WE_N), 32'(!(act && mwr)));
            check("oe_n", 32'(SRAM_OE_N), 32'(!(act && !mwr)));
            check("dq_oe", 32'(SRAM_DQ_oe), 32'(act && mwr));
            if (act) check("sram_addr", 32'(SRAM_ADDR), 32'({mword, ph_hi}));
            if (act && mwr)
                check("dq_out", 32'(SRAM_DQ_out),
                      32'(ph_hi ? mdata[31:16] : mdata[15:0]));
            check("read_data", read_data, m_rd);
        end
    end

    // Starts at posedge+1; returns at posedge+1 after the DONE cycle.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit release_after,
                          output int stalls, output logic [31:0] rd_done);
        MEM_r_en   = r;
        MEM_w_en   = w;
        address    = a;
        write_data = d;
        stalls     = 0;
        rd_done    = 32'hx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin
                rd_done = read_data;
                break;
            end
            stalls++;
        end
        @(posedge clk);
        #1;
        if (release_after) begin
            MEM_r_en = 0;
            MEM_w_en = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st;
        logic [31:0] rd;
        rst = 1;
        MEM_r_en = 0;
        MEM_w_en = 0;
        address = 0;
        write_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1;
        @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check("rst_sram_addr", 32'(SRAM_ADDR), 32'h0);
        check("rst_we_n", 32'(SRAM_WE_N), 32'h1);
        @(posedge clk);
        #1;
        rst = 0;

        // idle
        repeat (10) @(posedge clk);
        #1;

        // write 0xDEADBEEF @1028
        access(0, 1, 32'd1028, 32'hDEADBEEF, 1, st, rd);
        check("wr_stalls", st, 5);
        check("wr_sram2", 32'(sram[2]), 32'h0000BEEF);
        check("wr_sram3", 32'(sram[3]), 32'h0000DEAD);

        // read @1028
        access(1, 0, 32'd1028, 32'h0, 1, st, rd);
        check("rd_stalls", st, 5);
        check("rd_done_data", rd, 32'hDEADBEEF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rd_hold", read_data, 32'hDEADBEEF);
        @(posedge clk);
        #1;

        // back-to-back write then read @1024
        access(0, 1, 32'd1024, 32'h0BADCAFE, 0, st, rd);
        check("b2b_wr_stalls", st, 5);
        access(1, 0, 32'd1024, 32'h0, 1, st, rd);
        check("b2b_rd_stalls", st, 5);
        check("b2b_rd_data", rd, 32'h0BADCAFE);

        // reset during HIGH of a write
        MEM_r_en   = 0;
        MEM_w_en   = 1;
        address    = 32'd1032;
        write_data = 32'hA5A5C3C3;
        repeat (4) @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        MEM_w_en = 0;
        @(negedge clk);
        check("mr_we_n", 32'(SRAM_WE_N), 32'h1);
        check("mr_dq_oe", 32'(SRAM_DQ_oe), 32'h0);
        check("mr_ready", 32'(ready), 32'h1);
        check("mr_read_data", read_data, 32'h0);
        check("mr_sram_addr", 32'(SRAM_ADDR), 32'h0);
        @(posedge clk);
        #1;
        access(0, 1, 32'd1032, 32'hCAFEF00D, 1, st, rd);
        check("mr_next_stalls", st, 5);
        check("mr_next_sram4", 32'(sram[4]), 32'h0000F00D);

        // read back 1024 then dual-enable write
        access(1, 0, 32'd1024, 32'h0, 1, st, rd);
        check("rb_data", rd, 32'h0BADCAFE);
        access(1, 1, 32'd1032, 32'h12345678, 1, st, rd);
        check("dual_stalls", st, 5);
        check("dual_sram4", 32'(sram[4]), 32'h00005678);
        check("dual_sram5", 32'(sram[5]), 32'h00001234);
        check("dual_read_data", read_data, 32'h0BADCAFE);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
